fibonacci_engine: RTL and testbench

Parametrised successor to the team's fixed 16-bit Fibonacci calculator. Computes term n of any two-seed additive recurrence: Fibonacci, Lucas or custom seeds. Uses a start/busy/done handshake, a configurable data width, and a sticky overflow flag. Sits as a compute slave behind a control FSM or register bank. Each start launches one iterative calculation.

---
 rtl/fibonacci_engine_if.sv | 25 ++
 rtl/fibonacci_engine.sv | 90 +++++++++
 tb/tb_fibonacci_engine.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fibonacci_engine_if.sv
// Start/busy/done handshake bundle for fibonacci_engine.
// The master issues jobs (index and seeds); the slave computes and returns the result.
interface fibonacci_engine_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
);
  logic              start;
  logic [IDX_W-1:0]  index;
  logic [DATA_W-1:0] seed0;
  logic [DATA_W-1:0] seed1;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              overflow;

  modport master (
    output start, index, seed0, seed1,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, index, seed0, seed1,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/fibonacci_engine.sv
// Iterative two-seed additive recurrence engine: T(k+2) = T(k+1) + T(k) mod 2^DATA_W.
// One start launches one n+1 cycle calculation with a sticky overflow flag.
module fibonacci_engine #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  fibonacci_engine_if.slave  bus
);
  typedef enum logic {IDLE, CALC} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.seed0;
          b_d     = bus.seed1;
          cnt_d   = bus.index;
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          a_d   = b_q;
          b_d   = sum[DATA_W-1:0];
          cnt_d = cnt_q - IDX_W'(1);
          // On the final step the sum is T(n+1), which is never reported.
          if (cnt_q > IDX_W'(1) && sum[DATA_W]) begin
            ovf_d = 1'b1;
          end
        end else begin
          result_d   = a_q;
          overflow_d = ovf_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q == CALC);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_fibonacci_engine.sv
// Scoreboard bench for fibonacci_engine: driver pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares on every done.
module tb_fibonacci_engine;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic              ovf;
    int                cyc;
  } exp_t;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] last_res = '0;
  logic              last_ovf = 1'b0;
  bit                win_valid = 1'b0;
  int                win_lo = 0;
  int                win_hi = 0;

  fibonacci_engine_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  fibonacci_engine #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: compute the true (unbounded) sequence; overflow means any needed term >= 2^DATA_W.
  function automatic exp_t model(input int n, input logic [DATA_W-1:0] s0, input logic [DATA_W-1:0] s1);
    exp_t   e;
    longint t0 = longint'(s0);
    longint t1 = longint'(s1);
    longint t2;
    e.ovf = 1'b0;
    e.cyc = 0;
    if (n == 0) begin
      e.res = s0;
    end else begin
      for (int k = 2; k <= n; k++) begin
        t2 = t0 + t1;
        if (t2 >= (longint'(1) << DATA_W)) e.ovf = 1'b1;
        t0 = t1;
        t1 = t2;
      end
      e.res = DATA_W'(t1 % (longint'(1) << DATA_W));
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_result", 32'(bus.result), 0);
      check("rst_overflow", 32'(bus.overflow), 0);
    end else begin
      check("busy", 32'(bus.busy), 32'(win_valid && cyc >= win_lo && cyc <= win_hi));
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", 32'(bus.result), 32'(e.res));
          check("overflow", 32'(bus.overflow), 32'(e.ovf));
          check("done_cycle", cyc, e.cyc);
          $display("job done cycle %0d result %0d overflow %0d", cyc, bus.result, bus.overflow);
          last_res = e.res;
          last_ovf = e.ovf;
        end
      end else begin
        check("result_hold", 32'(bus.result), 32'(last_res));
        check("overflow_hold", 32'(bus.overflow), 32'(last_ovf));
        if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
          check("done_timeout", cyc, sb_q[0].cyc);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // Call while the engine is idle (or in its done cycle) before the next rising edge.
  task automatic issue_job(input int n, input logic [DATA_W-1:0] s0, input logic [DATA_W-1:0] s1);
    exp_t e;
    bus.start = 1'b1;
    bus.index = IDX_W'(n);
    bus.seed0 = s0;
    bus.seed1 = s1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.index = IDX_W'($urandom);
    bus.seed0 = DATA_W'($urandom);
    bus.seed1 = DATA_W'($urandom);
    e = model(n, s0, s1);
    e.cyc = cyc + n + 1;
    sb_q.push_back(e);
    win_lo = cyc;
    win_hi = cyc + n;
    win_valid = 1'b1;
    $display("job issued cycle %0d index %0d seeds %0d,%0d", cyc, n, s0, s1);
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    check("wait_done_bound", 0, 1);
  endtask

  task automatic pulse_while_busy();
    forever begin
      @(negedge clk);
      if (cyc >= win_hi) begin
        bus.start = 1'b0;
        break;
      end
      bus.start = 1'($urandom_range(0, 1));
      bus.index = IDX_W'($urandom);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.index = '0;
    bus.seed0 = '0;
    bus.seed1 = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);

    issue_job(10, 0, 1); wait_done();
    issue_job(0, 0, 1);  wait_done();
    issue_job(1, 0, 1);  wait_done();
    issue_job(10, 2, 1); wait_done();
    issue_job(5, 0, 1);  wait_done();
    repeat (2) @(negedge clk);
    issue_job(24, 0, 1); wait_done();
    issue_job(23, 0, 1); wait_done();
    issue_job(25, 0, 1); wait_done();
    repeat (2) @(negedge clk);

    issue_job(20, 0, 1);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    sb_q.delete();
    win_valid = 1'b0;
    last_res = '0;
    last_ovf = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_result", 32'(bus.result), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (30) @(negedge clk);

    issue_job(12, 0, 1); pulse_while_busy(); wait_done();
    repeat (3) @(negedge clk);

    for (int j = 0; j < 40; j++) begin
      int               n;
      logic [DATA_W-1:0] s0, s1;
      n = $urandom_range(0, (1 << IDX_W) - 1);
      case ($urandom_range(0, 2))
        0: begin s0 = 0; s1 = 1; end
        1: begin s0 = 2; s1 = 1; end
        default: begin s0 = DATA_W'($urandom); s1 = DATA_W'($urandom); end
      endcase
      issue_job(n, s0, s1);
      if ($urandom_range(0, 1) == 1) pulse_while_busy();
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    if (sb_q.size() != 0) check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
